// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: widths, RV32I opcodes,
// instruction field positions and a small opcode decoder.
package operand_fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  typedef struct packed {
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
  } decode_t;

  // Register usage implied by the opcode; unknown opcodes touch nothing.
  function automatic decode_t decode_opcode(input logic [6:0] opcode);
    decode_t d;
    d = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: d.writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        d.writes_rd = 1'b1;
        d.uses_rs1  = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      OP_OP: begin
        d.writes_rd = 1'b1;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction issues downstream, cleared by its writeback. x0 never pends.
module of_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] lookup_idx1,
  input  logic [REG_IDX_W-1:0] lookup_idx2,
  output logic                 lookup_pend1,
  output logic                 lookup_pend2
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_idx] = 1'b0;
    if (set_en) pending_next[set_idx] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Pending vector register, wiped by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  assign lookup_pend1 = pending[lookup_idx1];
  assign lookup_pend2 = pending[lookup_idx2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 from the register file, interlocks RAW
// hazards through a pending scoreboard and registers the instruction with
// its operands for execute.
// Optional feature macro: OPERAND_FETCH_WB_BYPASS_EN enables same-cycle
// forwarding of writeback data and lets a matching writeback lift the stall.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic [REG_IDX_W-1:0] rf_raddr1,
  output logic [REG_IDX_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val
);

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [REG_IDX_W-1:0] rs1_idx, rs2_idx, out_rd;
  decode_t              in_dec, out_dec;
  logic                 pend1, pend2;
  logic                 wb_hit1, wb_hit2;
  logic                 haz1, haz2;
  logic                 in_fire, out_fire, sb_set;
  logic [XLEN-1:0]      rs1_val, rs2_val;

  assign rs1_idx   = in_instr[RS1_MSB:RS1_LSB];
  assign rs2_idx   = in_instr[RS2_MSB:RS2_LSB];
  assign out_rd    = out_instr[RD_MSB:RD_LSB];
  assign in_dec    = decode_opcode(in_instr[OPCODE_MSB:OPCODE_LSB]);
  assign out_dec   = decode_opcode(out_instr[OPCODE_MSB:OPCODE_LSB]);
  assign rf_raddr1 = rs1_idx;
  assign rf_raddr2 = rs2_idx;
  assign wb_hit1   = wb_valid && (wb_rd == rs1_idx);
  assign wb_hit2   = wb_valid && (wb_rd == rs2_idx);

  of_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_en       (sb_set),
    .set_idx      (out_rd),
    .clr_en       (wb_valid),
    .clr_idx      (wb_rd),
    .lookup_idx1  (rs1_idx),
    .lookup_idx2  (rs2_idx),
    .lookup_pend1 (pend1),
    .lookup_pend2 (pend2)
  );

  // A source stalls if it is still pending downstream or is the destination
  // of the instruction currently parked in the output stage.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (in_dec.uses_rs1 && rs1_idx != '0) begin
      if (pend1 && !(BYPASS && wb_hit1)) haz1 = 1'b1;
      if (out_valid && out_dec.writes_rd && out_rd == rs1_idx) haz1 = 1'b1;
    end
    if (in_dec.uses_rs2 && rs2_idx != '0) begin
      if (pend2 && !(BYPASS && wb_hit2)) haz2 = 1'b1;
      if (out_valid && out_dec.writes_rd && out_rd == rs2_idx) haz2 = 1'b1;
    end
  end

  assign in_ready = !haz1 && !haz2 && (!out_valid || out_ready) && !flush;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign sb_set   = out_fire && !flush && out_dec.writes_rd;

  // Operand select: x0 reads zero, otherwise forward writeback or use the RF.
  always_comb begin
    rs1_val = (BYPASS && wb_hit1) ? wb_data : rf_rdata1;
    rs2_val = (BYPASS && wb_hit2) ? wb_data : rf_rdata2;
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end

  // Output stage: flush kills it, a new fire replaces it, a lone drain empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_instr   <= in_instr;
      out_pc      <= in_pc;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side reader for the integer register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register file's two combinational read ports (rs1, rs2). Registers the operands together with instr and pc into a single output stage for execute.
- A per-register pending scoreboard interlocks read-after-write hazards against instructions already issued downstream.
- Writeback traffic (the register file's write port) is snooped to clear pending bits and to bypass same-cycle write data.

Parameters:
XLEN, 32, data width of operands, pc and instr
NREG, 32, number of architectural registers (index width 5)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_instr  in  32  RV32I instruction word
in_pc  in  XLEN  instruction pc
rf_raddr1  out  5  register file read address 1 = in_instr[19:15]
rf_raddr2  out  5  register file read address 2 = in_instr[24:20]
rf_rdata1  in  XLEN  combinational read data 1
rf_rdata2  in  XLEN  combinational read data 2
wb_valid  in  1  register file write this cycle (mirrors RegWrite)
wb_rd  in  5  write register index
wb_data  in  XLEN  write data
flush  in  1  kill output stage (branch redirect)
out_valid  out  1  output stage holds an instruction
out_ready  in  1  execute accepts
out_instr  out  32  registered instruction
out_pc  out  XLEN  registered pc
out_rs1_val  out  XLEN  registered rs1 operand
out_rs2_val  out  XLEN  registered rs2 operand

Behaviour:
- Reset (rst low, async): out_valid=0; out_instr, out_pc, out_rs1_val, out_rs2_val = 0; pending[31:0]=0.
- Decode from opcode in_instr[6:0]:
  - writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - uses rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses rs2: BRANCH, STORE, OP.
  - Unknown opcode: no rd, no rs.
- Hazard on source rs (used, rs!=0) when any of:
  - (a) pending[rs]=1 and not (wb_valid and wb_rd==rs);
  - (b) out_valid=1, the output instruction writes rd, and its rd==rs.
- in_ready = !hazard and (!out_valid or out_ready) and !flush.
- in_fire = in_valid and in_ready. Registers load on the next rising edge, so latency is 1 cycle from in_fire to out_valid.
- Operand select per source:
  - rs==0: 0.
  - wb_valid and wb_rd==rs: wb_data (bypass).
  - otherwise: rf_rdataN.
- out_fire = out_valid and out_ready. Output holds stable while out_valid and !out_ready.
- Scoreboard:
  - out_fire with an rd-writing instruction and rd!=0 sets pending[rd].
  - wb_valid with wb_rd!=0 clears pending[wb_rd].
  - Same rd set and cleared in one cycle: set wins.
  - pending[0] is constant 0.
- flush:
  - Next edge out_valid=0, regardless of out_ready; no scoreboard set for the flushed instruction.
  - in_ready=0 that cycle.
  - Pending bits of already-issued instructions are untouched.
- Back-to-back: out_fire and in_fire in the same cycle replace the stage contents. No bubble unless a hazard exists.
- Reset mid-operation: the in-flight output instruction and all pending bits are lost immediately. Downstream must be reset together.

Optional Feature:
- Macro: OPERAND_FETCH_WB_BYPASS_EN.
- Defined: same-cycle wb_data bypass as above. Hazard (a) is masked by a matching writeback.
- Undefined:
  - No bypass; operands always come from rf_rdataN (or 0 for x0).
  - Hazard (a) is plain pending[rs]=1, with the clear still taking effect at the edge.
  - The instruction issues the cycle after writeback and reads the updated register file.
  - Costs one stall cycle per dependent writeback.

Decomposition:
- Package operand_fetch_pkg: XLEN default, RV32I opcode localparams (OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111, OP_BRANCH 1100011, OP_LOAD 0000011, OP_STORE 0100011, OP_IMM 0010011, OP_OP 0110011), field bit positions.
- Sub-module of_scoreboard: 32-bit pending vector with set/clear ports, set priority, two combinational lookup ports.

Test Plan:
- Reset then `addi x1,x0,5` (0x00500093, pc 0x0) with out_ready=1 -> out_valid=1 next cycle, out_instr=0x00500093, out_rs1_val=0; pending[1]=1 after out_fire.
- pending[1]=1, present `add x2,x1,x1` -> in_ready=0. Then wb_valid=1, wb_rd=1, wb_data=5 -> with bypass, in_fire that cycle and out_rs1_val=out_rs2_val=5. Without bypass, in_fire one cycle later with rf_rdata1=5.
- Output holds `lw x3,0(x0)` with out_ready=0, present `sw x3,4(x0)` -> in_ready=0 until out_fire. The sw enters only after pending[3] is cleared by wb_rd=3.
- out_ready=0 for 4 cycles with out_valid=1 -> out_* stable. Release -> out_fire, and the next instruction enters the same cycle (no bubble).
- flush=1 while out_valid=1 holding `addi x4,...` -> out_valid=0 next edge, pending[4] stays 0. A following `add x5,x4,x0` issues without stall.
- Writeback to x0 (wb_valid=1, wb_rd=0, wb_data=0xDEADBEEF) concurrent with a reader of x0 -> operand 0, pending[0] stays 0. Assert rst low mid-stream -> out_valid=0 and pending all 0 immediately.
